weight_updater: RTL and testbench
=================================

WEIGHT_UPDATER -- requirements
Module: weight_updater

Interface
REQ-001 The block SHALL use parameters HIST_LEN (default 8, history bits per row), WEIGHT_W (default 8, signed weight width), THETA (default 29, training threshold) and FIFO_DEPTH (default 4, pending-update entries).
REQ-002 Ports: i_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 Ports: i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 Ports: i_resolveValid  in  1  resolved conditional branch presented this cycle.
REQ-005 Ports: o_resolveReady  out  1  block accepts the resolve this cycle.
REQ-006 Ports: i_weightsAddr_8  in  8  perceptron row index, as generated at predict time.
REQ-007 Ports: i_ySum_12  in  12  signed perceptron output computed at predict time.
REQ-008 Ports: i_taken  in  1  actual branch direction.
REQ-009 Ports: i_ghr_8  in  8  global history snapshot used at predict time.
REQ-010 Ports: o_rdEn / o_rdAddr_8  out  1/8  weight-table read request.
REQ-011 Ports: i_rdData_72  in  72  row data, valid exactly one cycle after o_rdEn.
REQ-012 Ports: o_wrEn / o_wrAddr_8 / o_wrData_72  out  1/8/72  weight-table write.
REQ-013 Ports: o_busy  out  1  FIFO non-empty or FSM not in IDLE.
REQ-014 Row layout SHALL be: [7:0] bias w0; [8i+7:8i] weight wi for history bit i-1, i=1..8; all two's complement.

Function
REQ-015 A resolve SHALL be accepted iff i_resolveValid && o_resolveReady; o_resolveReady SHALL equal "FIFO not full", with no same-cycle pass-through.
REQ-016 Accepted resolves SHALL be filtered: train = (predicted != i_taken) || (|i_ySum_12| <= THETA), predicted = (i_ySum_12 >= 0); only train=1 entries are enqueued; train=0 resolves are accepted and dropped.
REQ-017 The FIFO SHALL hold {addr, taken, ghr}, FIFO_DEPTH entries, wrap-around pointers, in-order service; push and pop in the same cycle SHALL both take effect, including when full.
REQ-018 The FSM SHALL have states IDLE, WAIT, WRITE.
REQ-019 IDLE: if FIFO non-empty, assert o_rdEn=1 with o_rdAddr_8 = head addr, pop head into a working register, go WAIT; else stay.
REQ-020 WAIT: capture i_rdData_72, go WRITE.
REQ-021 WRITE: assert o_wrEn=1, o_wrAddr_8 = working addr, o_wrData_72 = updated row; go IDLE.
REQ-022 One update SHALL occupy exactly 3 cycles; an entry accepted in cycle t SHALL produce o_rdEn in t+1 (if FSM idle) and o_wrEn in t+3.
REQ-023 Update rule: w0 += (taken ? +1 : -1); wi += (taken == ghr[i-1]) ? +1 : -1.
REQ-024 Each weight SHALL saturate at [-128, +127]; no wrap-around.
REQ-025 o_rdEn and o_wrEn SHALL never be high in the same cycle; a read follows a write to the same row no earlier than the cycle after the write, so there is no RAW hazard.
REQ-026 o_rdAddr_8, o_wrAddr_8 and o_wrData_72 SHALL be 0 whenever their enable is low.

Reset
REQ-027 On i_rst_n low, regardless of clock: FSM to IDLE, FIFO empty, working register cleared, o_rdEn=0, o_wrEn=0, all addresses and data 0, o_busy=0, o_resolveReady=1.
REQ-028 Reset asserted mid-update SHALL abort it with no write issued; pending FIFO entries are discarded.
REQ-029 After reset deassertion, a resolve SHALL be acceptable on the first rising edge.

Verification
REQ-030 Accept addr=0x15, y=-5, taken=1, ghr=0xA5 -> o_rdEn at t+1 addr 0x15; rdData all 0 -> o_wrEn at t+3 with w0=+1, w1/3/6/8=+1, others -1.
REQ-031 y=+40, taken=1 (correct, |y|>THETA) -> accepted, no o_rdEn ever, o_busy stays 0.
REQ-032 rdData with w0=0x7F, taken=1, and a second row with w0=0x80, taken=0 -> written w0 stays 0x7F and 0x80 respectively.
REQ-033 Push 5 training resolves back-to-back with the FSM stalled -> o_resolveReady low after 4; the 5th is held; all 5 are written in order, 3 cycles apart.
REQ-034 Assert i_rst_n=0 in WAIT -> next cycles show o_wrEn=0, o_busy=0, o_resolveReady=1; no stale write after release.
REQ-035 Boundary y=+29 with a correct prediction -> trained; y=+30 -> not trained.

Source files
------------

// File: rtl/weight_updater.sv
// weight_updater: perceptron branch-predictor training engine.
// Filters resolves, queues training work and runs a read-modify-write on the weight table.
module weight_updater #(
    parameter int HIST_LEN   = 8,
    parameter int WEIGHT_W   = 8,
    parameter int THETA      = 29,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_resolveValid,
    output logic                             o_resolveReady,
    input  logic [7:0]                       i_weightsAddr_8,
    input  logic [11:0]                      i_ySum_12,
    input  logic                             i_taken,
    input  logic [HIST_LEN-1:0]              i_ghr_8,
    output logic                             o_rdEn,
    output logic [7:0]                       o_rdAddr_8,
    input  logic [WEIGHT_W*(HIST_LEN+1)-1:0] i_rdData_72,
    output logic                             o_wrEn,
    output logic [7:0]                       o_wrAddr_8,
    output logic [WEIGHT_W*(HIST_LEN+1)-1:0] o_wrData_72,
    output logic                             o_busy
);
    localparam int ROW_W = WEIGHT_W * (HIST_LEN + 1);
    localparam int ENT_W = 9 + HIST_LEN;
    localparam int PTR_W = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic signed [11:0] THR = 12'(THETA);
    localparam logic [WEIGHT_W-1:0] WMAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam logic [WEIGHT_W-1:0] WMIN = {1'b1, {(WEIGHT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, WAIT, WRITE} stateType;

    stateType            state;
    logic [ENT_W-1:0]    fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wrPtr, rdPtr;
    logic [CNT_W-1:0]    count;
    logic [ENT_W-1:0]    head;
    logic signed [11:0]  ySum;
    logic                train, push, pop;
    logic [7:0]          workAddr;
    logic                workTaken;
    logic [HIST_LEN-1:0] workGhr;
    logic [HIST_LEN:0]   agree;
    logic [ROW_W-1:0]    newRow;
    logic [WEIGHT_W-1:0] w;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return p == PTR_W'(FIFO_DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    // Sign bit equal to taken means the prediction was wrong.
    assign ySum           = i_ySum_12;
    assign train          = (ySum[11] == i_taken) || (ySum <= THR && ySum >= -THR);
    assign o_resolveReady = count != CNT_W'(FIFO_DEPTH);
    assign push           = i_resolveValid && o_resolveReady && train;
    assign pop            = state == IDLE && count != '0;
    assign head           = fifoMem[rdPtr];
    assign o_rdEn         = pop;
    assign o_rdAddr_8     = pop ? head[ENT_W-1 -: 8] : '0;
    assign o_busy         = count != '0 || state != IDLE;
    assign agree          = {~(workGhr ^ {HIST_LEN{workTaken}}), workTaken};

    always_comb begin
        newRow = '0;
        w = '0;
        for (int i = 0; i <= HIST_LEN; i++) begin
            w = i_rdData_72[i*WEIGHT_W +: WEIGHT_W];
            newRow[i*WEIGHT_W +: WEIGHT_W] = agree[i] ? (w == WMAX ? w : w + WEIGHT_W'(1))
                                                      : (w == WMIN ? w : w - WEIGHT_W'(1));
        end
    end

    always_ff @(posedge i_clk)
        if (push) fifoMem[wrPtr] <= {i_weightsAddr_8, i_taken, i_ghr_8};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            state       <= IDLE;
            workAddr    <= '0;
            workTaken   <= 1'b0;
            workGhr     <= '0;
            o_wrEn      <= 1'b0;
            o_wrAddr_8  <= '0;
            o_wrData_72 <= '0;
        end else begin
            wrPtr <= push ? nextPtr(wrPtr) : wrPtr;
            rdPtr <= pop ? nextPtr(rdPtr) : rdPtr;
            count <= count + CNT_W'(push) - CNT_W'(pop);
            case (state)
                IDLE: if (pop) begin
                    workAddr  <= head[ENT_W-1 -: 8];
                    workTaken <= head[HIST_LEN];
                    workGhr   <= head[HIST_LEN-1:0];
                    state     <= WAIT;
                end
                WAIT: begin
                    o_wrEn      <= 1'b1;
                    o_wrAddr_8  <= workAddr;
                    o_wrData_72 <= newRow;
                    state       <= WRITE;
                end
                default: begin
                    o_wrEn      <= 1'b0;
                    o_wrAddr_8  <= '0;
                    o_wrData_72 <= '0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_weight_updater.sv
// tb_weight_updater: vector table plus scoreboard against a behavioural weight-table model.
module tb_weight_updater;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, taken, rdy;
    logic [7:0]  addr, ghr;
    logic [11:0] ySum;
    logic        rdEn, wrEn, busy;
    logic [7:0]  rdAddr, wrAddr;
    logic [71:0] rdData, wrData;
    logic [71:0] mem [256];

    typedef struct { logic [7:0] a; logic tk; logic [7:0] g; } sbEnt;
    typedef struct { logic [7:0] a; int y; logic tk; logic [7:0] g; bit train; } vecT;

    sbEnt        sbQ[$];
    int          wrCycles[$];
    int          tests = 0, fails = 0, cyc = 0, lastRd = -1, lastWr = -1;
    logic [71:0] lastWrData = '0;

    weight_updater dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_resolveValid(valid), .o_resolveReady(rdy),
        .i_weightsAddr_8(addr), .i_ySum_12(ySum), .i_taken(taken), .i_ghr_8(ghr),
        .o_rdEn(rdEn), .o_rdAddr_8(rdAddr), .i_rdData_72(rdData),
        .o_wrEn(wrEn), .o_wrAddr_8(wrAddr), .o_wrData_72(wrData), .o_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rdData <= rdEn ? mem[rdAddr] : '0;

    task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [71:0] expRow(input logic [71:0] row, input logic tk, input logic [7:0] g);
        logic [71:0] r;
        for (int i = 0; i < 9; i++) begin
            int v;
            int d;
            v = $signed(row[8*i +: 8]);
            if (i == 0) d = tk ? 1 : -1;
            else d = (tk == g[i-1]) ? 1 : -1;
            v = v + d;
            if (v > 127) v = 127;
            if (v < -128) v = -128;
            r[8*i +: 8] = 8'(v);
        end
        return r;
    endfunction

    // Model of the weight table and the write-side scoreboard.
    initial begin
        sbEnt        e;
        logic [71:0] ex;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h40] = {9{8'h7F}};
        mem[8'h41] = {9{8'h80}};
        forever begin
            @(negedge clk);
            check("exclusive/zero-when-idle",
                  {rdEn && wrEn, !rdEn && rdAddr != 0, !wrEn && (wrAddr != 0 || wrData != 0)}, '0);
            if (!rst_n) sbQ.delete();
            if (rdEn) begin
                lastRd = cyc;
                if (sbQ.size() == 0) check("read with nothing pending", 1, 0);
                else check("rdAddr", rdAddr, sbQ[0].a);
            end
            if (wrEn) begin
                lastWr = cyc;
                lastWrData = wrData;
                wrCycles.push_back(cyc);
                if (sbQ.size() == 0) check("unexpected write", 1, 0);
                else begin
                    e = sbQ.pop_front();
                    ex = expRow(mem[e.a], e.tk, e.g);
                    check("wrAddr", wrAddr, e.a);
                    check("wrData", wrData, ex);
                    check("rd-to-wr latency", cyc - lastRd, 2);
                    mem[e.a] = ex;
                end
            end
        end
    end

    task automatic doResolve(input logic [7:0] a, input int y, input logic tk, input logic [7:0] g,
                             input bit tr, output int acc, output bit stalled);
        int n = 0;
        valid = 1'b1; addr = a; ySum = 12'(y); taken = tk; ghr = g;
        while (!rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        stalled = n > 0;
        acc = cyc;
        if (!rdy) begin
            check("ready timeout", 0, 1);
            valid = 1'b0;
            return;
        end
        if (tr) sbQ.push_back('{a, tk, g});
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int k = 0; k < 100; k++) begin
            if (!busy && sbQ.size() == 0) return;
            @(negedge clk);
        end
        check("drain timeout", 1, 0);
    endtask

    initial begin
        vecT vecs[12];
        int  acc, base, firstStall;
        bit  st;
        vecs = '{
            '{8'h20,    40, 1'b1, 8'h00, 1'b0},
            '{8'h21,    29, 1'b1, 8'h00, 1'b1},
            '{8'h22,    30, 1'b1, 8'h00, 1'b0},
            '{8'h23,   -29, 1'b0, 8'h3C, 1'b1},
            '{8'h24,   -30, 1'b0, 8'h00, 1'b0},
            '{8'h25,    40, 1'b0, 8'hFF, 1'b1},
            '{8'h26,  -100, 1'b1, 8'h0F, 1'b1},
            '{8'h27,     0, 1'b1, 8'h33, 1'b1},
            '{8'h28, -2048, 1'b0, 8'h00, 1'b0},
            '{8'h29,  2047, 1'b0, 8'h5A, 1'b1},
            '{8'h40,    -5, 1'b1, 8'hFF, 1'b1},
            '{8'h41,     5, 1'b0, 8'hFF, 1'b1}
        };
        rst_n = 1'b0; valid = 1'b0; addr = '0; ySum = '0; taken = 1'b0; ghr = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", {rdEn, wrEn, busy, rdy, rdAddr, wrAddr}, {4'b0001, 16'h0});
        check("reset wrData", wrData, '0);
        rst_n = 1'b1;

        // Resolve on the first edge after reset, all-zero row.
        doResolve(8'h15, -5, 1'b1, 8'hA5, 1'b1, acc, st);
        repeat (4) @(negedge clk);
        check("rdEn latency", lastRd - acc, 1);
        check("wrEn latency", lastWr - acc, 3);
        check("first row", lastWrData, 72'h01FF01FFFF01FF0101);

        for (int i = 0; i < 12; i++) begin
            base = wrCycles.size();
            doResolve(vecs[i].a, vecs[i].y, vecs[i].tk, vecs[i].g, vecs[i].train, acc, st);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (!vecs[i].train) check($sformatf("idle after vec %0d", i), busy | rdEn, 0);
            end
            waitDrain();
            check($sformatf("writes for vec %0d", i), wrCycles.size() - base, vecs[i].train);
            if (vecs[i].a == 8'h40) check("saturate high", lastWrData, {9{8'h7F}});
            if (vecs[i].a == 8'h41) check("saturate low", lastWrData, {9{8'h80}});
        end

        // Back-to-back burst: FIFO fills while the FSM drains one entry every 3 cycles.
        base = wrCycles.size();
        firstStall = -1;
        for (int i = 0; i < 8; i++) begin
            doResolve(8'h50 + 8'(i), -5, 1'b1, 8'(i), 1'b1, acc, st);
            if (st && firstStall < 0) firstStall = i;
        end
        waitDrain();
        check("accepted before full", firstStall, 6);
        check("burst writes", wrCycles.size() - base, 8);
        for (int i = 1; i < 8 && base + i < wrCycles.size(); i++)
            check($sformatf("burst spacing %0d", i), wrCycles[base+i] - wrCycles[base+i-1], 3);

        // Reset while the FSM waits for read data.
        doResolve(8'h60, -5, 1'b1, 8'h00, 1'b1, acc, st);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("reset abort", {wrEn, busy, rdy, rdEn}, 4'b0010);
        base = wrCycles.size();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        doResolve(8'h61, 5, 1'b0, 8'h0F, 1'b1, acc, st);
        check("post-reset accept", st, 0);
        waitDrain();
        check("post-reset writes", wrCycles.size() - base, 1);
        check("post-reset rd latency", lastRd - acc, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
